// File: rtl/eq_pkg.sv
// Shared types and helpers for the equalizer coefficient loader.
// Holds the sequencer state encoding plus coefficient and band-width helpers.
package eq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int unsigned unity_coeff(input int unsigned frac_bits);
        return 32'd1 << frac_bits;
    endfunction

    // Bins covered by one band in each FFT half.
    function automatic int unsigned band_width(input int unsigned samples,
                                               input int unsigned bands);
        return samples / (32'd2 * bands);
    endfunction

endpackage

// File: rtl/eq_band_map.sv
// Combinational bin-to-band lookup: upper FFT half mirrors onto the lower
// half, Nyquist maps to the top band.
module eq_band_map
    import eq_pkg::*;
#(
    parameter int SAMPLES   = 2048,
    parameter int NUM_BANDS = 32
) (
    input  logic [$clog2(SAMPLES)-1:0]   i_bin,
    output logic [$clog2(NUM_BANDS)-1:0] o_band
);

    localparam int IDX_W  = $clog2(SAMPLES);
    localparam int BAND_W = $clog2(NUM_BANDS);
    localparam int SHIFT  = $clog2(band_width(SAMPLES, NUM_BANDS));

    localparam logic [IDX_W-1:0]  HALF     = IDX_W'(SAMPLES / 2);
    localparam logic [BAND_W-1:0] BAND_MAX = BAND_W'(NUM_BANDS - 1);

    logic [IDX_W-1:0] w_mirror;

    // SAMPLES - k computed modulo 2^IDX_W, exact for every bin above HALF.
    assign w_mirror = (~i_bin) + IDX_W'(1'b1);

    // Select the band from the lower half directly or via the mirrored index.
    always_comb begin
        o_band = '0;
        if (i_bin == HALF) begin
            o_band = BAND_MAX;
        end else if (i_bin[IDX_W-1]) begin
            o_band = BAND_W'(w_mirror >> SHIFT);
        end else begin
            o_band = BAND_W'(i_bin >> SHIFT);
        end
    end

endmodule

// File: rtl/eq_coeff_loader.sv
// Turns staged per-band gains into a per-bin coefficient write sweep,
// pausing while the equalizer is mid-frame.
module eq_coeff_loader
    import eq_pkg::*;
#(
    parameter int SAMPLES             = 2048,
    parameter int NUM_BANDS           = 32,
    parameter int COEFF_BITS          = 8,
    parameter int COEFF_FRACTION_BITS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gain_valid,
    output logic                         gain_ready,
    input  logic [$clog2(NUM_BANDS)-1:0] gain_band,
    input  logic [COEFF_BITS-1:0]        gain_value,
    input  logic                         commit,
    input  logic                         frame_active,
    output logic                         coeff_wr_en,
    output logic [$clog2(SAMPLES)-1:0]   coeff_index,
    output logic [COEFF_BITS-1:0]        coeff_out,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W  = $clog2(SAMPLES);
    localparam int BAND_W = $clog2(NUM_BANDS);

    localparam logic [IDX_W-1:0]      LAST_BIN = IDX_W'(SAMPLES - 1);
    localparam logic [COEFF_BITS-1:0] UNITY    = COEFF_BITS'(unity_coeff(COEFF_FRACTION_BITS));

    state_t                r_state;
    logic [IDX_W-1:0]      r_k;
    logic                  r_pending;
    logic [COEFF_BITS-1:0] r_stage [NUM_BANDS];

    logic                  r_gain_ready;
    logic                  r_wr_en;
    logic [IDX_W-1:0]      r_index;
    logic [COEFF_BITS-1:0] r_out;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_emit;
    logic [BAND_W-1:0]     w_band;
    logic [COEFF_BITS-1:0] w_coeff;

    assign w_accept = gain_valid & r_gain_ready;

    eq_band_map #(
        .SAMPLES   (SAMPLES),
        .NUM_BANDS (NUM_BANDS)
    ) u_band_map (
        .i_bin  (r_k),
        .o_band (w_band)
    );

    // A gain landing in the same IDLE cycle as commit must reach bin 0.
    assign w_coeff = (w_accept && (gain_band == w_band)) ? gain_value : r_stage[w_band];

    // Decide whether a coefficient write is issued at the coming edge.
    always_comb begin
        w_emit = 1'b0;
        case (r_state)
            ST_IDLE:           w_emit = commit & ~frame_active;
            ST_WAIT, ST_WRITE: w_emit = ~frame_active;
            ST_DONE:           w_emit = (r_pending | commit) & ~frame_active;
            default:           w_emit = 1'b0;
        endcase
    end

    // Staging buffer: host writes land only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_stage[i] <= UNITY;
            end
        end else if (w_accept) begin
            r_stage[gain_band] <= gain_value;
        end
    end

    // Sequencer: state, bin counter, pending commit and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_pending    <= 1'b0;
            r_gain_ready <= 1'b1;
            r_wr_en      <= 1'b0;
            r_index      <= '0;
            r_out        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_wr_en <= w_emit;
            r_done  <= 1'b0;
            if (w_emit) begin
                r_index <= r_k;
                r_out   <= w_coeff;
                r_k     <= r_k + IDX_W'(1'b1);
            end
            case (r_state)
                ST_IDLE: begin
                    r_busy       <= commit;
                    r_gain_ready <= ~commit;
                    if (commit) begin
                        r_state <= frame_active ? ST_WAIT : ST_WRITE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    r_busy       <= 1'b1;
                    r_gain_ready <= 1'b0;
                    r_pending    <= r_pending | commit;
                    r_state      <= frame_active ? ST_WAIT : ST_WRITE;
                end
                ST_WRITE: begin
                    r_busy       <= 1'b1;
                    r_gain_ready <= 1'b0;
                    r_pending    <= r_pending | commit;
                    if (w_emit && (r_k == LAST_BIN)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_DONE: begin
                    // busy covers the done pulse cycle; ready returns after it.
                    r_busy       <= 1'b1;
                    r_gain_ready <= 1'b0;
                    r_done       <= 1'b1;
                    if (r_pending || commit) begin
                        r_pending <= 1'b0;
                        r_state   <= frame_active ? ST_WAIT : ST_WRITE;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gain_ready  = r_gain_ready;
    assign coeff_wr_en = r_wr_en;
    assign coeff_index = r_index;
    assign coeff_out   = r_out;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_eq_coeff_loader.sv
// Self-checking bench for eq_coeff_loader: directed sweeps, stall and reset
// corner cases, table lookups and a randomized sweep against a band model.
module tb_eq_coeff_loader;

    localparam int S  = 2048;
    localparam int NB = 32;
    localparam int BW = S / (2 * NB);

    logic        clk = 1'b0;
    logic        rst;
    logic        gain_valid;
    logic        gain_ready;
    logic [4:0]  gain_band;
    logic [7:0]  gain_value;
    logic        commit;
    logic        frame_active;
    logic        coeff_wr_en;
    logic [10:0] coeff_index;
    logic [7:0]  coeff_out;
    logic        busy;
    logic        done;

    logic [10:0] bm_bin;
    logic [4:0]  bm_band;

    always #5 clk = ~clk;

    eq_coeff_loader #(
        .SAMPLES(S), .NUM_BANDS(NB), .COEFF_BITS(8), .COEFF_FRACTION_BITS(5)
    ) dut (
        .clk(clk), .rst(rst), .gain_valid(gain_valid), .gain_ready(gain_ready),
        .gain_band(gain_band), .gain_value(gain_value), .commit(commit),
        .frame_active(frame_active), .coeff_wr_en(coeff_wr_en),
        .coeff_index(coeff_index), .coeff_out(coeff_out), .busy(busy), .done(done)
    );

    eq_band_map #(.SAMPLES(S), .NUM_BANDS(NB)) u_map (.i_bin(bm_bin), .o_band(bm_band));

    typedef struct { int bin; int exp; } vec_t;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         mon_k    = 0;
    int         n_writes = 0;
    int         n_dones  = 0;
    logic [7:0] stage [NB];
    logic [7:0] obs   [S];

    function automatic int band_of(input int k);
        if (k == S / 2) return NB - 1;
        if (k < S / 2) return k / BW;
        return (S - k) / BW;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every observed write must follow the stall rule, the bin order and the band model.
    task automatic monitor();
        if (coeff_wr_en === 1'b1) begin
            check("stall_rule", {31'd0, frame_active}, 32'd0);
            check("wr_index", {21'd0, coeff_index}, mon_k);
            check("wr_value", {24'd0, coeff_out}, {24'd0, stage[band_of(mon_k)]});
            obs[mon_k] = coeff_out;
            mon_k      = (mon_k + 1) % S;
            n_writes++;
        end
        if (done === 1'b1) n_dones++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic gain_write(input int band, input int val, input bit exp_ready);
        gain_valid = 1'b1;
        gain_band  = band[4:0];
        gain_value = val[7:0];
        check("gain_ready", {31'd0, gain_ready}, {31'd0, exp_ready});
        if (exp_ready) stage[band] = val[7:0];
        tick();
        gain_valid = 1'b0;
    endtask

    task automatic reset_model();
        for (int i = 0; i < NB; i++) stage[i] = 8'h20;
        mon_k = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bm_tbl [13];
        vec_t val_tbl[10];
        int   start;
        int   at;
        int   at2;
        bit   found;

        bm_tbl[0]  = '{0, 0};     bm_tbl[1]  = '{31, 0};    bm_tbl[2]  = '{32, 1};
        bm_tbl[3]  = '{512, 16};  bm_tbl[4]  = '{1023, 31}; bm_tbl[5]  = '{1024, 31};
        bm_tbl[6]  = '{1025, 31}; bm_tbl[7]  = '{1056, 31}; bm_tbl[8]  = '{1057, 30};
        bm_tbl[9]  = '{1536, 16}; bm_tbl[10] = '{2016, 1};  bm_tbl[11] = '{2017, 0};
        bm_tbl[12] = '{2047, 0};

        val_tbl[0] = '{0, 8'h40};    val_tbl[1] = '{31, 8'h40};   val_tbl[2] = '{32, 8'h20};
        val_tbl[3] = '{991, 8'h20};  val_tbl[4] = '{992, 8'h10};  val_tbl[5] = '{1024, 8'h10};
        val_tbl[6] = '{1056, 8'h10}; val_tbl[7] = '{1057, 8'h20}; val_tbl[8] = '{2016, 8'h20};
        val_tbl[9] = '{2047, 8'h40};

        rst = 1'b1; gain_valid = 1'b0; gain_band = 5'd0; gain_value = 8'd0;
        commit = 1'b0; frame_active = 1'b0; bm_bin = 11'd0;
        reset_model();

        // Standalone band map lookups.
        for (int i = 0; i < 13; i++) begin
            bm_bin = bm_tbl[i].bin[10:0];
            #1;
            check("band_map", {27'd0, bm_band}, bm_tbl[i].exp);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_gain_ready", {31'd0, gain_ready}, 32'd1);
        check("rst_wr_en", {31'd0, coeff_wr_en}, 32'd0);
        check("rst_index", {21'd0, coeff_index}, 32'd0);
        check("rst_out", {24'd0, coeff_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Unity sweep: latency, length and done/busy timing.
        n_writes = 0; n_dones = 0;
        commit = 1'b1; start = cyc;
        tick();
        commit = 1'b0;
        check("lat_wr_en", {31'd0, coeff_wr_en}, 32'd1);
        check("lat_index", {21'd0, coeff_index}, 32'd0);
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("ready_fall", {31'd0, gain_ready}, 32'd0);
        wait_done(2100, at);
        check("done_cycle", at - start, S + 1);
        check("sweep_len_a", n_writes, S);
        check("busy_at_done", {31'd0, busy}, 32'd1);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("ready_back", {31'd0, gain_ready}, 32'd1);

        // Band 31 staged first, band 0 written in the same cycle as commit.
        gain_write(31, 8'h10, 1'b1);
        n_writes = 0;
        gain_valid = 1'b1; gain_band = 5'd0; gain_value = 8'h40; commit = 1'b1;
        check("gain_ready_commit", {31'd0, gain_ready}, 32'd1);
        stage[0] = 8'h40;
        tick();
        gain_valid = 1'b0; commit = 1'b0;
        wait_done(2100, at);
        check("sweep_len_b", n_writes, S);
        for (int i = 0; i < 10; i++) begin
            check("bin_value", {24'd0, obs[val_tbl[i].bin]}, val_tbl[i].exp);
        end
        tick();

        // Commit while the equalizer is mid-frame for 10 cycles.
        n_writes = 0;
        frame_active = 1'b1; commit = 1'b1;
        tick();
        commit = 1'b0;
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_no_wr", {31'd0, coeff_wr_en}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("wait_no_wr", {31'd0, coeff_wr_en}, 32'd0);
        end
        frame_active = 1'b0;
        tick();
        check("wait_first_wr", {31'd0, coeff_wr_en}, 32'd1);
        check("wait_first_idx", {21'd0, coeff_index}, 32'd0);

        // Three-cycle pause right after bin 499.
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (coeff_wr_en === 1'b1 && coeff_index == 11'd499) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reach_499", {31'd0, found}, 32'd1);
        frame_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_no_wr", {31'd0, coeff_wr_en}, 32'd0);
        end
        frame_active = 1'b0;
        tick();
        check("resume_wr", {31'd0, coeff_wr_en}, 32'd1);
        check("resume_idx", {21'd0, coeff_index}, 32'd500);
        wait_done(2100, at);
        check("sweep_len_c", n_writes, S);
        tick();

        // Two commits mid-sweep collapse into one extra sweep; busy blocks gains.
        n_writes = 0; n_dones = 0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (100) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (50) tick();
        gain_write(5, 8'h77, 1'b0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wait_done(2100, at);
        wait_done(2100, at2);
        repeat (10) tick();
        check("double_commit_writes", n_writes, 2 * S);
        check("double_commit_dones", n_dones, 2);
        check("double_commit_idle", {31'd0, busy}, 32'd0);
        check("double_commit_ready", {31'd0, gain_ready}, 32'd1);

        // Asynchronous reset at bin 1200.
        n_writes = 0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            if (coeff_wr_en === 1'b1 && coeff_index == 11'd1200) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reach_1200", {31'd0, found}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wr_en", {31'd0, coeff_wr_en}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_index", {21'd0, coeff_index}, 32'd0);
        check("arst_out", {24'd0, coeff_out}, 32'd0);
        check("arst_ready", {31'd0, gain_ready}, 32'd1);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_no_wr", {31'd0, coeff_wr_en}, 32'd0);
        n_writes = 0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wait_done(2100, at);
        check("sweep_len_rst", n_writes, S);
        tick();

        // Randomized gains and frame stalls against the band model.
        for (int i = 0; i < 12; i++) begin
            gain_write($urandom_range(0, NB - 1), $urandom_range(0, 255), 1'b1);
        end
        n_writes = 0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        at = -1;
        for (int i = 0; i < 6000; i++) begin
            frame_active = ($urandom_range(0, 7) == 0);
            tick();
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check("rand_done_seen", {31'd0, (at >= 0)}, 32'd1);
        check("sweep_len_rand", n_writes, S);
        frame_active = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
